// File: rtl/coco_md_ctrl.sv
// Multiply/divide sequencing controller: clears HI/LO, runs the unit until Ready,
// services MTHI/MTLO writes and MFHI/MFLO reads, and stalls EX while busy.
module coco_md_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        OpValid,
    input  logic [3:0]  Op,
    input  logic        Flush,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic        Ready,
    input  logic [31:0] DC,
    output logic [31:0] Ain,
    output logic [31:0] Bin,
    output logic        Start,
    output logic        MorD,
    output logic        HorL,
    output logic        Sign,
    output logic        We,
    output logic        Stall,
    output logic [31:0] RdData,
    output logic        RdValid
);

    typedef enum logic [2:0] {
        IDLE, CLR_HI, CLR_LO, RUN, DRAIN, WRITE
    } state_t;

    state_t      state;
    logic [31:0] a_lat;
    logic        hl_reg;
    logic        op_live;
    logic        accept;
    logic        is_md;
    logic        is_mt;
    logic        is_mf;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        is_md = 1'b0;
        is_mt = 1'b0;
        is_mf = 1'b0;
        case (Op)
            4'd1, 4'd2, 4'd3, 4'd4: is_md = 1'b1;
            4'd5, 4'd6:             is_mf = 1'b1;
            4'd7, 4'd8:             is_mt = 1'b1;
            default:                ;
        endcase
    end

    assign op_live = OpValid && !Flush && (is_md || is_mt || is_mf);
    assign accept  = op_live && (state == IDLE);
    assign Stall   = op_live && (state != IDLE);
    assign RdValid = accept && is_mf;
    assign RdData  = DC;
    // A read must select HI/LO in the same cycle it is accepted, so HorL bypasses the register.
    assign HorL    = RdValid ? (Op == 4'd5) : hl_reg;

    // NOTE: sequential state uses non-blocking assignments; the asynchronous reset clears
    // every register, including the latched operand, so nothing survives into the next op.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            a_lat  <= '0;
            Ain    <= '0;
            Bin    <= '0;
            Start  <= 1'b0;
            MorD   <= 1'b0;
            Sign   <= 1'b0;
            We     <= 1'b0;
            hl_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_md) begin
                        a_lat  <= RsData;
                        Bin    <= RtData;
                        MorD   <= (Op == 4'd1) || (Op == 4'd2);
                        Sign   <= (Op == 4'd1) || (Op == 4'd3);
                        Ain    <= '0;
                        We     <= 1'b1;
                        hl_reg <= 1'b1;
                        state  <= CLR_HI;
                    end else if (accept && is_mt) begin
                        Ain    <= RsData;
                        We     <= 1'b1;
                        hl_reg <= (Op == 4'd7);
                        state  <= WRITE;
                    end
                end
                CLR_HI: begin
                    hl_reg <= 1'b0;
                    state  <= CLR_LO;
                end
                CLR_LO: begin
                    We    <= 1'b0;
                    Start <= 1'b1;
                    Ain   <= a_lat;
                    state <= RUN;
                end
                RUN: begin
                    if (Ready) begin
                        Start <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                WRITE: begin
                    We     <= 1'b0;
                    hl_reg <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coco_md_ctrl.sv
// Bench for coco_md_ctrl: a behavioural multiply/divide unit answers the controller,
// directed ops push expected reads and Start lengths, and a monitor compares them.
module tb_coco_md_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        OpValid;
    logic [3:0]  Op;
    logic        Flush;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        Ready;
    logic [31:0] DC;
    logic [31:0] Ain;
    logic [31:0] Bin;
    logic        Start;
    logic        MorD;
    logic        HorL;
    logic        Sign;
    logic        We;
    logic        Stall;
    logic [31:0] RdData;
    logic        RdValid;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rd_q[$];
    int          start_q[$];

    coco_md_ctrl dut (
        .Clk(Clk), .Reset(Reset), .OpValid(OpValid), .Op(Op), .Flush(Flush),
        .RsData(RsData), .RtData(RtData), .Ready(Ready), .DC(DC),
        .Ain(Ain), .Bin(Bin), .Start(Start), .MorD(MorD), .HorL(HorL),
        .Sign(Sign), .We(We), .Stall(Stall), .RdData(RdData), .RdValid(RdValid)
    );

    always #5 Clk = ~Clk;

    // Multiply/divide unit: accumulates into HI/LO, Ready on the last Start cycle.
    logic [31:0] hi = '0;
    logic [31:0] lo = '0;
    int          cnt = 0;
    logic        model_ready;
    logic        extra_ready = 1'b0;

    assign model_ready = Start && (cnt == (MorD ? 32 : 34));
    assign Ready       = model_ready || extra_ready;
    assign DC          = HorL ? hi : lo;

    function automatic logic [63:0] unit_result(input logic [31:0] a, input logic [31:0] b,
                                                input logic md, input logic sg,
                                                input logic [63:0] acc);
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        if (md) begin
            if (sg) p = $signed(a) * $signed(b);
            else    p = {32'd0, a} * {32'd0, b};
            return acc + p;
        end
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge Clk) begin
        if (We) begin
            if (HorL) hi <= Ain;
            else      lo <= Ain;
        end
        if (Start) begin
            cnt <= cnt + 1;
            if (model_ready) {hi, lo} <= unit_result(Ain, Bin, MorD, Sign, {hi, lo});
        end else begin
            cnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expected read data on RdValid and expected Start length when Start falls.
    int run_len = 0;
    always begin
        @(negedge Clk);
        #2;
        if (RdValid) begin
            if (rd_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got RdValid with RdData 0x%08h, expected no read", RdData);
            end else begin
                check("rd_data", RdData, rd_q.pop_front());
            end
        end
        if (Start) begin
            run_len++;
        end else if (run_len > 0) begin
            if (start_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL start_unexpected: got Start run of %0d cycles, expected none", run_len);
            end else begin
                int e;
                e = start_q.pop_front();
                if (e >= 0) check("start_cycles", run_len, e);
            end
            run_len = 0;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output int stalls);
        stalls = 0;
        @(negedge Clk);
        OpValid = 1'b1;
        Op      = op;
        Flush   = 1'b0;
        RsData  = rs;
        RtData  = rt;
        #1;
        while (Stall && stalls < 500) begin
            stalls++;
            @(negedge Clk);
            #1;
        end
        if (Stall) begin
            n_vec++;
            n_err++;
            $display("FAIL stall_timeout: got Stall stuck for op %0d, expected release", op);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            OpValid = 1'b0;
            Op      = 4'd0;
            Flush   = 1'b0;
        end
    endtask

    task automatic mf(input logic [3:0] op, input logic [31:0] exp);
        int s;
        rd_q.push_back(exp);
        issue(op, 32'd0, 32'd0, s);
    endtask

    task automatic md(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input int len);
        int s;
        start_q.push_back(len);
        issue(op, rs, rt, s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        Reset   = 1'b1;
        OpValid = 1'b0;
        Op      = 4'd0;
        Flush   = 1'b0;
        RsData  = '0;
        RtData  = '0;

        repeat (2) @(negedge Clk);
        #1;
        check("rst_start", Start, 0);
        check("rst_we", We, 0);
        check("rst_ain", Ain, 0);
        check("rst_bin", Bin, 0);
        check("rst_mord", MorD, 0);
        check("rst_sign", Sign, 0);
        check("rst_horl", HorL, 0);
        check("rst_rdvalid", RdValid, 0);
        check("rst_stall", Stall, 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Flushed MULT in IDLE, with a stray Ready: nothing may move.
        extra_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            OpValid = 1'b1; Op = 4'd1; Flush = 1'b1; RsData = 32'd5; RtData = 32'd5;
            #1;
            check("flush_stall", Stall, 0);
            check("flush_start", Start, 0);
            check("flush_we", We, 0);
        end
        @(negedge Clk);
        Op = 4'd5;
        #1;
        check("flush_mf_rdvalid", RdValid, 0);

        // Ops 0 and 9-15 are no-ops.
        for (int op = 0; op < 16; op++) begin
            if (op == 0 || op >= 9) begin
                @(negedge Clk);
                OpValid = 1'b1; Op = 4'(op); Flush = 1'b0;
                #1;
                check("none_stall", Stall, 0);
                check("none_rdvalid", RdValid, 0);
                check("none_we", We, 0);
                check("none_start", Start, 0);
            end
        end
        extra_ready = 1'b0;
        issue(4'd8, 32'h0000_CAFE, 32'd0, s);
        check("mtlo_from_idle_stalls", s, 0);
        mf(4'd6, 32'h0000_CAFE);

        // Signed MULT with clear-sequence checks; Ready forced during the clears.
        md(4'd1, 32'hFFFF_FFFE, 32'd3, 33);
        @(negedge Clk);
        OpValid = 1'b0; Op = 4'd0; extra_ready = 1'b1;
        #1;
        check("clrhi_we", We, 1);
        check("clrhi_horl", HorL, 1);
        check("clrhi_ain", Ain, 0);
        check("clrhi_start", Start, 0);
        @(negedge Clk);
        #1;
        check("clrlo_we", We, 1);
        check("clrlo_horl", HorL, 0);
        check("clrlo_ain", Ain, 0);
        check("clrlo_start", Start, 0);
        @(negedge Clk);
        extra_ready = 1'b0;
        #1;
        check("run_start", Start, 1);
        check("run_we", We, 0);
        check("run_ain", Ain, 32'hFFFF_FFFE);
        check("run_bin", Bin, 32'd3);
        check("run_mord", MorD, 1);
        check("run_sign", Sign, 1);
        mf(4'd5, 32'hFFFF_FFFF);
        mf(4'd6, 32'hFFFF_FFFA);

        // DIVU with flushed ops presented mid-run.
        md(4'd4, 32'd100, 32'd7, 35);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            OpValid = 1'b1; Op = 4'd1; Flush = 1'b1;
            #1;
            check("run_flush_stall", Stall, 0);
        end
        mf(4'd6, 32'd14);
        mf(4'd5, 32'd2);

        // MFLO presented while the multiply is in flight.
        md(4'd1, 32'h0001_0000, 32'h0001_0003, 33);
        rd_q.push_back(32'h0003_0000);
        issue(4'd6, 32'd0, 32'd0, s);
        check("mflo_stall_cycles", s, 36);
        mf(4'd5, 32'd1);

        // MTHI then a MULTU that must start from a cleared HI/LO.
        issue(4'd7, 32'h1234_5678, 32'd0, s);
        mf(4'd5, 32'h1234_5678);
        md(4'd2, 32'd2, 32'd3, 33);
        mf(4'd5, 32'd0);
        mf(4'd6, 32'd6);

        // Reset in the middle of RUN.
        md(4'd1, 32'd7, 32'd7, -1);
        idle(10);
        @(negedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check("midrst_start", Start, 0);
        check("midrst_we", We, 0);
        check("midrst_ain", Ain, 0);
        check("midrst_mord", MorD, 0);
        check("midrst_sign", Sign, 0);
        @(negedge Clk);
        Reset = 1'b0;
        md(4'd2, 32'd5, 32'd5, 33);
        mf(4'd6, 32'd25);
        mf(4'd5, 32'd0);

        idle(5);
        check("rd_queue_left", rd_q.size(), 0);
        check("start_queue_left", start_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/coco_md_ctrl.md
COCO_MD_CTRL -- requirements
Module: coco_md_ctrl

Interface
REQ-001 SHALL have no parameters; widths fixed at 32-bit data, 4-bit opcode.
REQ-002 Clk  input  1  clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 OpValid  input  1  EX-stage instruction valid.
REQ-005 Op  input  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as none.
REQ-006 Flush  input  1  kill current EX instruction; suppresses Op this cycle.
REQ-007 RsData, RtData  input  32 each  register operands.
REQ-008 Ready  input  1  completion from multiply/divide unit.
REQ-009 DC  input  32  HI or LO read data from multiply/divide unit.
REQ-010 Ain, Bin  output  32 each  operands/write data to multiply/divide unit.
REQ-011 Start, MorD, HorL, Sign, We  output  1 each  multiply/divide unit controls (MorD=1 multiply, HorL=1 HI).
REQ-012 Stall  output  1  freeze EX and earlier stages.
REQ-013 RdData  output  32  MFHI/MFLO result; RdValid  output  1  RdData valid this cycle.

Function
REQ-014 Accepted op SHALL mean OpValid=1, Flush=0, Op in 1-8, state IDLE.
REQ-015 FSM states SHALL be IDLE, CLR_HI, CLR_LO, RUN, DRAIN, WRITE.
REQ-016 IDLE + accepted MULT/MULTU/DIV/DIVU SHALL latch RsData->Ain reg, RtData->Bin reg, MorD=(Op 1/2), Sign=(Op 1/3); next state CLR_HI.
REQ-017 CLR_HI SHALL drive We=1, HorL=1, Ain=0, Start=0 for one cycle -> CLR_LO.
REQ-018 CLR_LO SHALL drive We=1, HorL=0, Ain=0, Start=0 for one cycle -> RUN (HILO must be zero before Start; unit accumulates).
REQ-019 RUN SHALL drive Start=1, We=0, latched Ain/Bin/MorD/Sign held constant; -> DRAIN on the cycle Ready=1.
REQ-020 Start SHALL be high exactly 33 cycles for multiply, 35 for divide (Ready included).
REQ-021 DRAIN SHALL drive Start=0, We=0 for one cycle (clears unit counter) -> IDLE.
REQ-022 IDLE + accepted MTHI/MTLO SHALL latch RsData->Ain, HorL=(Op==7); WRITE drives We=1, Start=0 one cycle -> IDLE.
REQ-023 IDLE + accepted MFHI/MFLO SHALL combinationally drive HorL=(Op==5), RdData=DC, RdValid=1 same cycle; state stays IDLE.
REQ-024 In IDLE without MF op: HorL=0, Start=0, We=0; RdValid=0 in all other cases.
REQ-025 Stall SHALL equal OpValid & !Flush & Op in 1-8 & state!=IDLE (combinational); stalled op re-presented and accepted first IDLE cycle.
REQ-026 Ops 0, 9-15 SHALL never stall or change state.
REQ-027 Flush SHALL not abort an operation already past IDLE.
REQ-028 Outputs other than HorL/RdData/RdValid/Stall SHALL be registered.
REQ-029 Ready outside RUN SHALL be ignored.

Reset
REQ-030 Reset SHALL force IDLE; Ain=Bin=0, Start=MorD=Sign=We=0, HorL=0, RdValid=0, Stall=0, asynchronously, including mid-RUN.
REQ-031 First accepted op after Reset release SHALL behave as from IDLE with no residual latched state.

Verification
REQ-032 MULT Rs=0xFFFFFFFE Rt=3 -> CLR_HI, CLR_LO, Start high 33 cycles, DRAIN; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
REQ-033 DIVU Rs=100 Rt=7 -> Start high 35 cycles; MFLO=14, MFHI=2.
REQ-034 MFLO presented during RUN -> Stall=1 every cycle through DRAIN; first IDLE cycle RdValid=1, RdData=product low word.
REQ-035 MTHI 0x12345678, then MFHI -> 0x12345678; then MULTU 2x3 -> HI=0, LO=6 (confirms clear).
REQ-036 Reset pulsed mid-RUN -> Start=0, We=0 immediately; then MULTU 5x5 -> LO=25, HI=0.
REQ-037 OpValid MULT with Flush=1 in IDLE -> no state change, Start/We stay 0, Stall=0.
